// File: rtl/lvds_tx_peripheral_pkg.sv
// Shared definitions for the LVDS transmit peripheral: test-pattern modes,
// register addresses, CTRL field positions and the PRBS7 generator step.
package lvds_pkg;

    typedef enum logic [1:0] {
        LVDS_NORMAL = 2'd0,
        LVDS_PRBS   = 2'd1,
        LVDS_ALT    = 2'd2,
        LVDS_IDLE   = 2'd3
    } lvds_mode_e;

    localparam int ADDR_CTRL        = 0;
    localparam int ADDR_STATUS      = 1;
    localparam int ADDR_SHADOW_BASE = 2;

    localparam int CTRL_EN_BIT     = 0;
    localparam int CTRL_MODE_LSB   = 1;
    localparam int CTRL_COMMIT_BIT = 3;

    localparam logic [6:0] PRBS_SEED = 7'h7F;

    // x^7 + x^6 + 1, shifting towards the MSB; the MSB is the emitted bit
    function automatic logic [6:0] prbs7_step(input logic [6:0] state);
        return {state[5:0], state[6] ^ state[5]};
    endfunction

endpackage

// File: rtl/lvds_tx_peripheral_if.sv
// CPU-side register bus of the LVDS transmit peripheral.
interface lvds_bus_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 16
);
    logic              cs;
    logic              wr;
    logic              rd;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] d_in;
    logic [DATA_W-1:0] d_out;

    modport master (output cs, wr, rd, addr, d_in, input d_out);
    modport slave  (input cs, wr, rd, addr, d_in, output d_out);
endinterface

// File: rtl/lvds_tx_peripheral_ser_lane.sv
// One serial data lane: ACTIVE frame register loaded on commit, MSB-first
// bit select and the test-pattern mux feeding a registered pad output.
module lvds_ser_lane
    import lvds_pkg::*;
#(
    parameter int SER_FACTOR = 7
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  lvds_mode_e                    mode,
    input  logic [$clog2(SER_FACTOR)-1:0] bit_cnt,
    input  logic                          prbs_bit,
    input  logic                          load,
    input  logic [SER_FACTOR-1:0]         load_data,
    output logic                          ser_out
);
    localparam int CNT_W = $clog2(SER_FACTOR);

    logic [SER_FACTOR-1:0] active_q, active_d;
    logic                  ser_q, ser_d;
    logic [CNT_W-1:0]      bit_idx;

    assign bit_idx = CNT_W'(SER_FACTOR - 1) - bit_cnt;

    always_comb begin
        active_d = load ? load_data : active_q;
        ser_d    = 1'b0;
        if (en) begin
            case (mode)
                LVDS_NORMAL: ser_d = active_q[bit_idx];
                LVDS_PRBS:   ser_d = prbs_bit;
                LVDS_ALT:    ser_d = ~bit_cnt[0];
                LVDS_IDLE:   ser_d = 1'b0;
                default:     ser_d = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            active_q <= '0;
            ser_q    <= 1'b0;
        end else begin
            active_q <= active_d;
            ser_q    <= ser_d;
        end
    end

    assign ser_out = ser_q;

endmodule

// File: rtl/lvds_tx_peripheral.sv
// Bus-mapped LVDS transmitter: register decode, shadow registers, bit/frame
// counters, PRBS generator and forwarded clock lane around NUM_CH lanes.
module lvds_tx_peripheral
    import lvds_pkg::*;
#(
    parameter int NUM_CH     = 3,
    parameter int SER_FACTOR = 7,
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 4
) (
    input  logic              clk,
    input  logic              rst,
    lvds_bus_if.slave         bus,
    output logic [NUM_CH-1:0] ch_p,
    output logic [NUM_CH-1:0] ch_n,
    output logic              clock_p,
    output logic              clock_n
);
    localparam int CNT_W = $clog2(SER_FACTOR);

    logic                         en_q, en_d;
    lvds_mode_e                   mode_q, mode_d;
    logic                         commit_pend_q, commit_pend_d;
    logic [CNT_W-1:0]             bit_cnt_q, bit_cnt_d;
    logic [15:0]                  frame_cnt_q, frame_cnt_d;
    logic [6:0]                   prbs_q, prbs_d;
    logic                         clock_q, clock_d;
    logic [DATA_W-1:0]            d_out_q, d_out_d;

    logic                         wr_en, rd_en, ctrl_wr;
    logic                         frame_end, transfer;
    logic [DATA_W-1:0]            rd_data;
    logic [NUM_CH*SER_FACTOR-1:0] shadow_flat;

    assign wr_en     = bus.cs && bus.wr;
    assign rd_en     = bus.cs && bus.rd;
    assign ctrl_wr   = wr_en && (bus.addr == ADDR_W'(ADDR_CTRL));
    assign frame_end = en_q && (bit_cnt_q == CNT_W'(SER_FACTOR - 1));
    // A pending commit lands at the frame boundary, or straight away when idle
    assign transfer  = commit_pend_q && (frame_end || !en_q);

    always_comb begin
        en_d   = en_q;
        mode_d = mode_q;
        if (ctrl_wr) begin
            en_d   = bus.d_in[CTRL_EN_BIT];
            mode_d = lvds_mode_e'(bus.d_in[CTRL_MODE_LSB +: 2]);
        end
        // A fresh COMMIT on the transfer edge must survive for the next frame
        commit_pend_d = (commit_pend_q && !transfer) ||
                        (ctrl_wr && bus.d_in[CTRL_COMMIT_BIT]);

        if (!en_q || frame_end) begin
            bit_cnt_d = '0;
        end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
        frame_cnt_d = frame_end ? frame_cnt_q + 16'd1 : frame_cnt_q;
        prbs_d      = (en_q && mode_q == LVDS_PRBS) ? prbs7_step(prbs_q) : prbs_q;
        clock_d     = en_q && (bit_cnt_q < CNT_W'((SER_FACTOR + 1) / 2));
    end

    always_comb begin
        rd_data = '0;
        if (bus.addr == ADDR_W'(ADDR_CTRL)) begin
            rd_data = DATA_W'({commit_pend_q, mode_q, en_q});
        end else if (bus.addr == ADDR_W'(ADDR_STATUS)) begin
            rd_data = DATA_W'(frame_cnt_q);
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (bus.addr == ADDR_W'(ADDR_SHADOW_BASE + k)) begin
                    rd_data = DATA_W'(shadow_flat[k*SER_FACTOR +: SER_FACTOR]);
                end
            end
        end
        d_out_d = rd_en ? rd_data : d_out_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            en_q          <= 1'b0;
            mode_q        <= LVDS_NORMAL;
            commit_pend_q <= 1'b0;
            bit_cnt_q     <= '0;
            frame_cnt_q   <= '0;
            prbs_q        <= PRBS_SEED;
            clock_q       <= 1'b0;
            d_out_q       <= '0;
        end else begin
            en_q          <= en_d;
            mode_q        <= mode_d;
            commit_pend_q <= commit_pend_d;
            bit_cnt_q     <= bit_cnt_d;
            frame_cnt_q   <= frame_cnt_d;
            prbs_q        <= prbs_d;
            clock_q       <= clock_d;
            d_out_q       <= d_out_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_lane
            logic [SER_FACTOR-1:0] shadow_q, shadow_d;
            logic                  shadow_wr;

            assign shadow_wr = wr_en && (bus.addr == ADDR_W'(ADDR_SHADOW_BASE + gi));

            always_comb begin
                shadow_d = shadow_q;
                if (shadow_wr) begin
                    shadow_d = bus.d_in[SER_FACTOR-1:0];
                end
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    shadow_q <= '0;
                end else begin
                    shadow_q <= shadow_d;
                end
            end

            assign shadow_flat[gi*SER_FACTOR +: SER_FACTOR] = shadow_q;

            lvds_ser_lane #(
                .SER_FACTOR (SER_FACTOR)
            ) u_lane (
                .clk       (clk),
                .rst       (rst),
                .en        (en_q),
                .mode      (mode_q),
                .bit_cnt   (bit_cnt_q),
                .prbs_bit  (prbs_q[6]),
                .load      (transfer),
                .load_data (shadow_q),
                .ser_out   (ch_p[gi])
            );
        end
    endgenerate

    assign ch_n      = ~ch_p;
    assign clock_p   = clock_q;
    assign clock_n   = ~clock_q;
    assign bus.d_out = d_out_q;

endmodule

// File: tb/tb_lvds_tx_peripheral.sv
// Directed bench for lvds_tx_peripheral: vector table of lane patterns plus
// hand sequences for commit timing, PRBS, status counting and bus corners.
module tb_lvds_tx_peripheral;
    localparam int NUM_CH     = 3;
    localparam int SER_FACTOR = 7;
    localparam int DATA_W     = 16;
    localparam int ADDR_W     = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [NUM_CH-1:0] ch_p, ch_n;
    logic              clock_p, clock_n;

    lvds_bus_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    lvds_tx_peripheral #(
        .NUM_CH     (NUM_CH),
        .SER_FACTOR (SER_FACTOR),
        .DATA_W     (DATA_W),
        .ADDR_W     (ADDR_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .ch_p    (ch_p),
        .ch_n    (ch_n),
        .clock_p (clock_p),
        .clock_n (clock_n)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct packed {
        logic [15:0] sh0;
        logic [15:0] sh1;
        logic [15:0] sh2;
        logic [1:0]  mode;
        logic [6:0]  exp0;
        logic [6:0]  exp1;
        logic [6:0]  exp2;
        logic [15:0] rb0;
    } vec_t;

    vec_t vecs [6];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] pads();
        return 32'({clock_n, clock_p, ch_n, ch_p});
    endfunction

    task automatic bus_write(input logic [3:0] a, input logic [15:0] d);
        bus.cs = 1'b1; bus.wr = 1'b1; bus.rd = 1'b0; bus.addr = a; bus.d_in = d;
        @(negedge clk);
        bus.cs = 1'b0; bus.wr = 1'b0;
        $display("wr addr=0x%0h data=0x%04h", a, d);
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [15:0] d);
        bus.cs = 1'b1; bus.rd = 1'b1; bus.wr = 1'b0; bus.addr = a;
        @(negedge clk);
        bus.cs = 1'b0; bus.rd = 1'b0;
        d = bus.d_out;
        $display("rd addr=0x%0h data=0x%04h", a, d);
    endtask

    task automatic check_read(input string name, input logic [3:0] a, input logic [15:0] exp);
        logic [15:0] d;
        bus_read(a, d);
        check(name, 32'(d), 32'(exp));
    endtask

    // Checks frame positions start..6 against MSB-first lane patterns
    task automatic check_frame_from(input string name, input logic [6:0] e0,
                                    input logic [6:0] e1, input logic [6:0] e2,
                                    input int start);
        logic [6:0] cp;
        cp = 7'b1111000;
        for (int p = start; p < SER_FACTOR; p++) begin
            logic [2:0] l;
            logic       c;
            @(negedge clk);
            l = {e2[6-p], e1[6-p], e0[6-p]};
            c = cp[6-p];
            check($sformatf("%s pos%0d", name, p), pads(), 32'({~c, c, ~l, l}));
        end
        $display("frame %s lanes %07b %07b %07b from pos %0d", name, e0, e1, e2, start);
    endtask

    initial begin
        logic [15:0] rd;
        logic [6:0]  m;
        logic [15:0] first16;

        bus.cs = 1'b0; bus.wr = 1'b0; bus.rd = 1'b0; bus.addr = '0; bus.d_in = '0;
        rst = 1'b0;

        vecs[0] = '{16'h0055, 16'h007F, 16'h0000, 2'd0, 7'b1010101, 7'b1111111, 7'b0000000, 16'h0055};
        vecs[1] = '{16'h000F, 16'h0040, 16'h0001, 2'd0, 7'b0001111, 7'b1000000, 7'b0000001, 16'h000F};
        vecs[2] = '{16'h002A, 16'h0033, 16'h007E, 2'd0, 7'b0101010, 7'b0110011, 7'b1111110, 16'h002A};
        vecs[3] = '{16'hFFAA, 16'h0001, 16'h0040, 2'd0, 7'b0101010, 7'b0000001, 7'b1000000, 16'h002A};
        vecs[4] = '{16'h000F, 16'h0040, 16'h0001, 2'd2, 7'b1010101, 7'b1010101, 7'b1010101, 16'h000F};
        vecs[5] = '{16'h007F, 16'h007F, 16'h007F, 2'd3, 7'b0000000, 7'b0000000, 7'b0000000, 16'h007F};

        repeat (3) @(negedge clk);
        check("reset_pads", pads(), 32'h0000_00B8);
        check("reset_dout", 32'(bus.d_out), 32'h0);
        rst = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 6; v++) begin
            bus_write(4'h0, 16'h0000);
            bus_write(4'h2, vecs[v].sh0);
            bus_write(4'h3, vecs[v].sh1);
            bus_write(4'h4, vecs[v].sh2);
            check_read($sformatf("vec%0d_rb0", v), 4'h2, vecs[v].rb0);
            bus_write(4'h0, 16'h0008);
            bus_write(4'h0, {13'd0, vecs[v].mode, 1'b1});
            check_frame_from($sformatf("vec%0d", v), vecs[v].exp0, vecs[v].exp1, vecs[v].exp2, 0);
        end

        // Commit requested while disabled transfers on the very next edge
        bus_write(4'h0, 16'h0000);
        bus_write(4'h2, 16'h0011);
        bus_write(4'h0, 16'h0008);
        check_read("idle_commit_pend", 4'h0, 16'h0008);
        check_read("idle_commit_done", 4'h0, 16'h0000);
        bus_write(4'h0, 16'h0001);
        check_frame_from("idle_commit", 7'b0010001, 7'b1111111, 7'b1111111, 0);

        // Double buffering: shadow write mid-frame without COMMIT
        bus_write(4'h0, 16'h0000);
        bus_write(4'h2, 16'h0055);
        bus_write(4'h3, 16'h007F);
        bus_write(4'h4, 16'h0000);
        bus_write(4'h0, 16'h0008);
        bus_write(4'h0, 16'h0001);
        repeat (3) @(negedge clk);
        bus_write(4'h2, 16'h000F);
        repeat (3) @(negedge clk);
        for (int f = 0; f < 3; f++) begin
            check_frame_from($sformatf("dbuf_hold%0d", f), 7'b1010101, 7'b1111111, 7'b0000000, 0);
        end
        bus_write(4'h0, 16'h0009);
        check_frame_from("dbuf_commit_frame", 7'b1010101, 7'b1111111, 7'b0000000, 1);
        check_frame_from("dbuf_new", 7'b0001111, 7'b1111111, 7'b0000000, 0);

        // COMMIT written exactly on the frame-end edge
        bus_write(4'h2, 16'h0033);
        repeat (5) @(negedge clk);
        bus_write(4'h0, 16'h0009);
        check_read("collide_pend", 4'h0, 16'h0009);
        check_frame_from("collide_old", 7'b0001111, 7'b1111111, 7'b0000000, 1);
        check_frame_from("collide_new", 7'b0110011, 7'b1111111, 7'b0000000, 0);
        check_read("collide_cleared", 4'h0, 16'h0001);

        // Asynchronous reset with traffic running, checked before any edge
        rst = 1'b0;
        #1;
        check("midrst_pads", pads(), 32'h0000_00B8);
        check("midrst_dout", 32'(bus.d_out), 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        check_read("midrst_status", 4'h1, 16'h0000);
        check_read("midrst_ctrl", 4'h0, 16'h0000);
        check_read("midrst_shadow0", 4'h2, 16'h0000);

        // PRBS7 from the reset seed
        bus_write(4'h0, 16'h0003);
        m = 7'h7F;
        first16 = '0;
        for (int i = 0; i < 254; i++) begin
            logic b;
            @(negedge clk);
            b = m[6];
            check($sformatf("prbs bit%0d", i), 32'(ch_p), 32'({3{b}}));
            if (i < 16) first16 = {first16[14:0], ch_p[0]};
            m = {m[5:0], m[6] ^ m[5]};
        end
        check("prbs_first16", 32'(first16), 32'h0000_FE04);
        $display("prbs 254 bits compared, first16=0x%04h", first16);

        // Frame counting, abort on disable
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        bus_write(4'h0, 16'h0001);
        repeat (70) @(negedge clk);
        bus.cs = 1'b1; bus.rd = 1'b1; bus.addr = 4'h1;
        #1;
        check("status_latency", 32'(bus.d_out), 32'h0);
        @(negedge clk);
        bus.cs = 1'b0; bus.rd = 1'b0;
        check("status_10", 32'(bus.d_out), 32'h000A);
        $display("rd addr=0x1 data=0x%04h", bus.d_out);
        repeat (3) @(negedge clk);
        bus_write(4'h0, 16'h0000);
        repeat (20) @(negedge clk);
        check("disabled_pads", pads(), 32'h0000_00B8);
        check_read("status_abort", 4'h1, 16'h000A);
        check_read("ctrl_disabled", 4'h0, 16'h0000);

        // Bus corner cases
        bus_write(4'h5, 16'hFFFF);
        bus_write(4'h1, 16'h1234);
        check_read("status_ro", 4'h1, 16'h000A);
        check_read("unmapped_5", 4'h5, 16'h0000);
        check_read("status_again", 4'h1, 16'h000A);
        bus.cs = 1'b0; bus.rd = 1'b1; bus.addr = 4'h5;
        @(negedge clk);
        bus.rd = 1'b0;
        check("rd_no_cs_hold", 32'(bus.d_out), 32'h000A);
        $display("rd without cs addr=0x5 data=0x%04h", bus.d_out);
        check_read("unmapped_f", 4'hF, 16'h0000);
        bus_write(4'h3, 16'h0011);
        bus.cs = 1'b1; bus.wr = 1'b1; bus.rd = 1'b1; bus.addr = 4'h3; bus.d_in = 16'h0022;
        @(negedge clk);
        bus.cs = 1'b0; bus.wr = 1'b0; bus.rd = 1'b0;
        check("wr_rd_same_addr", 32'(bus.d_out), 32'h0011);
        $display("wr+rd addr=0x3 data=0x0022 read=0x%04h", bus.d_out);
        check_read("wr_rd_after", 4'h3, 16'h0022);
        bus.cs = 1'b0; bus.wr = 1'b1; bus.addr = 4'h3; bus.d_in = 16'h007F;
        @(negedge clk);
        bus.wr = 1'b0;
        check_read("wr_no_cs", 4'h3, 16'h0022);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/lvds_tx_peripheral.md
Name: lvds_tx_peripheral

Overview:
Parametrised bus-mapped LVDS transmit peripheral: NUM_CH data lanes plus one forwarded clock lane, each serialising SER_FACTOR bits per frame.
- Double-buffered lane registers, committed atomically at frame boundaries.
- Built-in test-pattern modes and registered readback of all registers.
- Sits between the CPU-side register bus (cs/wr/addr/d_in) and the differential pad drivers. Supersedes the fixed 3-lane register/serialiser pair.

Parameters:
NUM_CH, 3, number of data lanes (1..8)
SER_FACTOR, 7, bits per lane per frame (2..16)
DATA_W, 16, bus data width (>= SER_FACTOR)
ADDR_W, 4, bus address width (2^ADDR_W >= NUM_CH+2)

Ports:
clk  in  1  bit clock; one serial bit per rising edge
rst  in  1  asynchronous, active-low reset
cs  in  1  chip select
wr  in  1  write strobe (qualified by cs)
rd  in  1  read strobe (qualified by cs)
addr  in  ADDR_W  register address
d_in  in  DATA_W  write data
d_out  out  DATA_W  read data, registered
ch_p  out  NUM_CH  lane positive outputs
ch_n  out  NUM_CH  lane negative outputs, always ~ch_p
clock_p  out  1  forwarded clock positive
clock_n  out  1  forwarded clock negative, always ~clock_p

Behaviour:
- Reset (rst low, asynchronous): all registers 0, bit_cnt=0, frame_cnt=0, commit_pend=0, PRBS state=7'h7F. Outputs: ch_p=0, ch_n=all 1, clock_p=0, clock_n=1, d_out=0.
- Register map:
  - 0x0 CTRL (RW): bit0 EN; bits2:1 MODE; bit3 COMMIT (write-1 sets commit_pend, reads as commit_pend).
  - 0x1 STATUS (RO): bits15:0 frame_cnt.
  - 0x2+k SHADOW[k], k<NUM_CH (RW): low SER_FACTOR bits stored, upper bits read 0.
  - Unmapped addresses: writes ignored, read 0.
- Write: cs&&wr at rising edge updates the addressed register.
- Read: cs&&rd loads d_out on the next edge (1-cycle latency); otherwise d_out holds. cs&&wr&&rd to the same address: d_out returns the pre-write value.
- bit_cnt counts 0..SER_FACTOR-1 while EN=1, then wraps; held at 0 while EN=0.
- Frame end = EN && bit_cnt==SER_FACTOR-1. At frame end: frame_cnt+1 (wraps 0xFFFF->0); if commit_pend, ACTIVE[k]<=SHADOW[k] for all k and commit_pend cleared.
- EN=0 with commit_pend: transfer happens on the next edge.
- Same-edge collisions:
  - COMMIT written on a frame-end edge: applies at the following frame end.
  - SHADOW written on the transfer edge: ACTIVE takes the old SHADOW value.
- Lane output while EN=1, bit index i=SER_FACTOR-1-bit_cnt (MSB first), registered, one cycle after bit_cnt:
  - MODE 0: ACTIVE[k][i].
  - MODE 1: PRBS7 (x^7+x^6+1) bit on all lanes; LFSR advances one step per clk.
  - MODE 2: bit_cnt[0] ? 0 : 1 (1010...).
  - MODE 3: 0.
- EN=0: ch_p=0, clock_p=0.
- Clock lane while EN=1: clock_p = (bit_cnt < (SER_FACTOR+1)/2), aligned with the data lanes. SER_FACTOR=7 gives 1111000.
- Disabling mid-frame aborts the frame immediately: no frame_cnt increment, no commit.
- MODE change mid-frame takes effect on the next bit.

Decomposition:
- Package lvds_pkg:
  - mode enum: LVDS_NORMAL=0, LVDS_PRBS=1, LVDS_ALT=2, LVDS_IDLE=3
  - address constants: ADDR_CTRL, ADDR_STATUS, ADDR_SHADOW_BASE
  - CTRL bit positions
  - PRBS seed 7'h7F
- Sub-module lvds_ser_lane, instantiated NUM_CH times: ACTIVE register, load strobe, bit select and mode mux.
- Top level holds: bus decode, shadow registers, bit/frame counters, PRBS LFSR, clock lane.

Test Plan:
- Reset: assert rst=0 mid-traffic -> ch_p=000, ch_n=111, clock_p=0, d_out=0 with no clk edge; STATUS read after release returns 0.
- Normal mode: SHADOW0=0x55, SHADOW1=0x7F, SHADOW2=0x00, CTRL=0x9 -> after transfer, lane0 serialises 1010101, lane1 1111111, lane2 0000000; clock_p 1111000 each frame.
- Double buffering: write SHADOW0=0x0F at bit_cnt=3 without COMMIT -> lane0 unchanged for 3 frames. Write CTRL=0x9 -> 0001111 from the next frame only.
- Commit collision: COMMIT written on a frame-end edge -> transfer at the following frame end; CTRL bit3 reads 1 in between.
- PRBS: CTRL=0x3 -> all lanes match the reference LFSR model, first bit 1; sequence repeats after 127 bits.
- Status/readback: run 10 frames -> STATUS read returns 0x000A one cycle after rd. Disable at bit_cnt=4 -> count stays 0x000A. Unmapped address reads 0.
